// File: rtl/multiplier.sv
// Radix-2 shift-and-add 32x32 multiplier (signed/unsigned) sharing an external adder.
// Latency: start edge + 32 iteration edges; completed rises after the 33rd edge from start.
// Backpressure: none; MultE is a level request, the result is held in DONE until MultE drops.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   SrcAE, SrcBE    - multiplicand / multiplier, sampled only on the start edge
//   MultE, MultSgn  - start/hold request, signed-mode select (sampled at start)
//   ALUOut, ALU_zero- sum from the shared external adder; zero flag is unused
//   ALU_A, ALU_B    - operands presented to the shared adder (zero outside RUN)
//   hi, lo          - 64-bit product register halves
//   completed       - high while the final product is held on {hi,lo}
module multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        MultE,
    input  logic        MultSgn,
    input  logic [31:0] ALUOut,
    input  logic        ALU_zero,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        completed
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] mcand;
    logic        neg;
    logic [4:0]  count;

    logic        carry;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] step_res;
    logic [63:0] final_res;
    logic        unused_zero;

    // The zero flag of the shared ALU carries no information for this unit.
    assign unused_zero = ALU_zero;

    assign completed = (state == DONE);

    // Magnitudes for signed mode; 0x80000000 negates to itself and is then
    // treated as the unsigned value 2^31, which is exactly its magnitude.
    assign abs_a = (MultSgn && SrcAE[31]) ? (~SrcAE + 32'd1) : SrcAE;
    assign abs_b = (MultSgn && SrcBE[31]) ? (~SrcBE + 32'd1) : SrcBE;

    always_comb begin
        ALU_A = '0;
        ALU_B = '0;
        if (state == RUN) begin
            ALU_A = hi;
            ALU_B = lo[0] ? mcand : '0;
        end
    end

    // The external adder only returns 32 bits; a wrap-around shows up as a
    // sum smaller than either operand.
    assign carry     = (ALUOut < ALU_A);
    assign step_res  = {carry, ALUOut, lo[31:1]};
    assign final_res = neg ? (~step_res + 64'd1) : step_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            neg   <= 1'b0;
            mcand <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MultE) begin
                        mcand <= abs_a;
                        lo    <= abs_b;
                        hi    <= '0;
                        neg   <= MultSgn & (SrcAE[31] ^ SrcBE[31]);
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        {hi, lo} <= final_res;
                        state    <= DONE;
                    end else begin
                        {hi, lo} <= step_res;
                    end
                end
                DONE: begin
                    if (!MultE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the shift-and-add multiplier with a model of the shared adder.
// Latency: each operation is expected to complete exactly 33 edges after its start edge.
// Backpressure: the bench drops MultE after each result to return the unit to IDLE.
module tb_multiplier;

    logic        clk;
    logic        rst;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MultE;
    logic        MultSgn;
    logic [31:0] ALUOut;
    logic        ALU_zero;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        completed;

    int checks = 0;
    int errors = 0;

    multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .MultE     (MultE),
        .MultSgn   (MultSgn),
        .ALUOut    (ALUOut),
        .ALU_zero  (ALU_zero),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .hi        (hi),
        .lo        (lo),
        .completed (completed)
    );

    // Shared ALU in add mode.
    assign ALUOut   = ALU_A + ALU_B;
    assign ALU_zero = (ALUOut == 32'd0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Count edges from the start edge until completed, scrambling the
    // operand inputs and pulsing MultE low mid-run, then check the result,
    // the hold behaviour, and the return to IDLE.
    task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  edges;
        bit  done;
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (completed) begin
                done = 1'b1;
            end else if (edges == 5) begin
                @(negedge clk);
                SrcAE   = $urandom;
                SrcBE   = $urandom;
                MultSgn = ~MultSgn;
                MultE   = 1'b0;
            end else if (edges == 6) begin
                @(negedge clk);
                MultE = 1'b1;
            end
        end
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_product"}, {hi, lo}, {exp_hi, exp_lo});
        check({tag, "_alu_done"}, {ALU_A, ALU_B}, 64'd0);
        // MultE still high: one operation only, result held.
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_cmpl"}, 64'(completed), 64'd1);
        check({tag, "_hold_prod"}, {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        MultE = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_cmpl"}, 64'(completed), 64'd0);
        check({tag, "_drop_prod"}, {hi, lo}, {exp_hi, exp_lo});
        check({tag, "_idle_alu"}, {ALU_A, ALU_B}, 64'd0);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        SrcAE   = a;
        SrcBE   = b;
        MultSgn = sgn;
        MultE   = 1'b1;
        rst     = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        SrcAE   = 32'h33;
        SrcBE   = 32'h33;
        MultSgn = 1'b0;
        MultE   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_cmpl", 64'(completed), 64'd0);
        check("rst_alu", {ALU_A, ALU_B}, 64'd0);

        // 51 * 51 = 2601, MultE already held high through reset.
        start_op(32'h33, 32'h33, 1'b0);
        wait_done("u33x33", 32'h0000_0000, 32'h0000_0A29);

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("uffxff", 32'hFFFF_FFFE, 32'h0000_0001);

        start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done("s_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("s_m1xm1", 32'h0000_0000, 32'h0000_0001);

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("s_minxmin", 32'h4000_0000, 32'h0000_0000);

        // 0x12345678 * 0x9ABCDEF0 unsigned = 0x0B00EA4E_242D2080
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_done("u_mixed", 32'h0B00_EA4E, 32'h242D_2080);

        // Abort at iteration 10 with asynchronous reset.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_cmpl", 64'(completed), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_held", {hi, lo}, 64'd0);

        start_op(32'd7, 32'd6, 1'b0);
        wait_done("restart7x6", 32'h0000_0000, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 SrcAE  input  32  multiplicand; sampled only at operation start.
REQ-005 SrcBE  input  32  multiplier; sampled only at operation start.
REQ-006 MultE  input  1  start/hold request; level-sensitive.
REQ-007 MultSgn  input  1  1 = signed (two's complement) multiply, 0 = unsigned; sampled at start.
REQ-008 ALUOut  input  32  sum returned by the external shared adder, ALU in add mode: ALUOut = ALU_A + ALU_B mod 2^32, combinational same cycle.
REQ-009 ALU_zero  input  1  external ALU zero flag; accepted and ignored.
REQ-010 ALU_A  output  32  adder operand A, driven combinationally from state.
REQ-011 ALU_B  output  32  adder operand B, driven combinationally from state.
REQ-012 hi  output  32  upper 32 bits of the 64-bit product register.
REQ-013 lo  output  32  lower 32 bits of the 64-bit product register.
REQ-014 completed  output  1  1 while the final product is held on {hi,lo}.

Function
REQ-015 SHALL be a radix-2 shift-and-add multiplier with three states IDLE, RUN, DONE; completed = (state == DONE), decoded from state.
REQ-016 IDLE: ALU_A = ALU_B = 0; on a clock edge with MultE=1, SHALL latch mcand = |SrcAE| if MultSgn else SrcAE, set lo = |SrcBE| if MultSgn else SrcBE, hi = 0, neg = MultSgn & (SrcAE[31] ^ SrcBE[31]), count = 0, go to RUN.
REQ-017 The absolute value SHALL be the two's-complement negation for negative operands; |0x80000000| = 0x80000000 treated as unsigned.
REQ-018 RUN: ALU_A = hi, ALU_B = lo[0] ? mcand : 0; carry = (ALUOut < ALU_A) unsigned, computed internally.
REQ-019 RUN, each edge: {hi,lo} <= {carry, ALUOut, lo[31:1]}, i.e. the 65-bit value {carry, ALUOut, lo} shifted right by one; count increments.
REQ-020 Exactly 32 RUN iterations; on the 32nd edge, the register SHALL receive the iteration result, 64-bit two's-complement negated if neg=1, and state goes to DONE.
REQ-021 Latency: start edge plus 32 iteration edges; completed rises after the 33rd rising edge counted from the start edge.
REQ-022 DONE: hi/lo hold the product; ALU_A = ALU_B = 0; stay while MultE=1; MultE=0 returns to IDLE with hi/lo retained and completed dropping to 0.
REQ-023 SrcAE, SrcBE, MultSgn and MultE changes during RUN SHALL be ignored; hi/lo hold intermediate values during RUN and are valid only when completed=1.
REQ-024 MultE held high continuously SHALL produce exactly one operation; a new start requires passing through IDLE.

Reset
REQ-025 rst=0 SHALL asynchronously set state = IDLE, hi = 0, lo = 0, count = 0, neg = 0, mcand = 0, completed = 0; this applies mid-operation and aborts it.
REQ-026 After rst returns to 1, with MultE=1 a new operation starts on the next rising edge.

Verification
REQ-027 Unsigned 0x33 * 0x33, MultE held 1 after reset pulse -> completed=1 after 33 edges, hi=0x00000000, lo=0x00000A29, then holds.
REQ-028 Unsigned 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 Signed -3 (0xFFFFFFFD) * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed -1 * -1 -> hi=0, lo=1.
REQ-030 Signed 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 rst=0 at iteration 10 -> hi=lo=0 and completed=0 immediately; a restart with 7*6 yields lo=42 after 33 edges.
REQ-032 After DONE, drop MultE one cycle -> completed=0, hi/lo retained; reassert with new operands -> new correct result.
